// File: rtl/mem_bus_arbiter_pkg.sv
// rtl/mem_bus_arbiter_pkg.sv - shared bus2 encodings, cache geometry and arbiter state type
package mem_bus_arbiter_pkg;

    localparam int CACHE_TAG_SIZE  = 7;
    localparam int CACHE_SET_SIZE  = 5;
    localparam int CACHE_LINE_SIZE = 16;
    localparam int DATA2_BUS_SIZE  = 16;

    localparam logic [1:0] C2_NOP        = 2'd0;
    localparam logic [1:0] C2_RESPONSE   = 2'd1;
    localparam logic [1:0] C2_READ_LINE  = 2'd2;
    localparam logic [1:0] C2_WRITE_LINE = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_SEND,
        ST_WR_WAIT,
        ST_RD_CMD,
        ST_RD_WAIT,
        ST_RD_DATA,
        ST_DONE
    } arb_state_e;

endpackage

// File: rtl/line_beat_shifter.sv
// rtl/line_beat_shifter.sv - cache line to bus2 beat serializer and beat-to-line fill capture
module line_beat_shifter #(
    parameter int LINE_W = 128,
    parameter int DATA_W = 16
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              load_i,
    input  logic [LINE_W-1:0] line_i,
    input  logic              shift_i,
    input  logic              clr_i,
    input  logic              cap_i,
    input  logic [DATA_W-1:0] d_i,
    output logic              last_o,
    output logic [DATA_W-1:0] d_out_o,
    output logic [LINE_W-1:0] fill_line_o
);

    localparam int N      = LINE_W / DATA_W;
    localparam int BEAT_W = (N > 1) ? $clog2(N) : 1;

    logic [BEAT_W-1:0] beat_q;
    logic [BEAT_W-1:0] beat_nx;
    logic [LINE_W-1:0] wr_line_q;
    logic [LINE_W-1:0] fill_q;
    logic [DATA_W-1:0] d_out_q;

    assign beat_nx     = beat_q + 1'b1;
    assign last_o      = (beat_q == BEAT_W'(N - 1));
    assign d_out_o     = d_out_q;
    assign fill_line_o = fill_q;

    // Outgoing beat is registered one edge ahead, so the next slice is selected here.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            beat_q    <= '0;
            wr_line_q <= '0;
            fill_q    <= '0;
            d_out_q   <= '0;
        end else begin
            d_out_q <= '0;
            if (load_i) begin
                wr_line_q <= line_i;
                beat_q    <= '0;
                d_out_q   <= line_i[DATA_W-1:0];
            end else if (shift_i) begin
                beat_q  <= beat_nx;
                d_out_q <= wr_line_q[int'(beat_nx)*DATA_W +: DATA_W];
            end else if (clr_i) begin
                beat_q <= '0;
            end else if (cap_i) begin
                fill_q[int'(beat_q)*DATA_W +: DATA_W] <= d_i;
                if (!last_o) begin
                    beat_q <= beat_nx;
                end
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - writeback/fill arbiter driving the shared bus2 memory interface
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W     = CACHE_TAG_SIZE + CACHE_SET_SIZE,
    parameter int DATA_W     = DATA2_BUS_SIZE,
    parameter int LINE_BYTES = CACHE_LINE_SIZE,
    parameter int TIMEOUT    = 255
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    wb_req,
    input  logic [ADDR_W-1:0]       wb_addr,
    input  logic [LINE_BYTES*8-1:0] wb_line,
    output logic                    wb_ack,
    input  logic                    fill_req,
    input  logic [ADDR_W-1:0]       fill_addr,
    output logic                    fill_ack,
    output logic [LINE_BYTES*8-1:0] fill_line,
    output logic [1:0]              c2_out,
    output logic                    c2_oe,
    output logic [ADDR_W-1:0]       a2_out,
    output logic [DATA_W-1:0]       d2_out,
    output logic                    d2_oe,
    input  logic [1:0]              c2_in,
    input  logic [DATA_W-1:0]       d2_in,
    output logic                    busy,
    output logic                    timeout_err
);

    localparam int LINE_W = LINE_BYTES * 8;
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    arb_state_e        state_q;
    logic              is_wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        c2_out_q;
    logic              c2_oe_q;
    logic              d2_oe_q;
    logic              wb_ack_q;
    logic              fill_ack_q;
    logic              busy_q;
    logic              timeout_q;
    logic [WAIT_W-1:0] wait_cnt_q;

    logic load_d, clr_d, shift_d, cap_d;
    logic resp, wait_expired, beat_last;

    assign resp         = (c2_in == C2_RESPONSE);
    assign wait_expired = (wait_cnt_q == WAIT_W'(TIMEOUT - 1));

    always_comb begin
        load_d  = (state_q == ST_IDLE) && wb_req;
        clr_d   = (state_q == ST_IDLE) && !wb_req && fill_req;
        shift_d = (state_q == ST_WR_SEND) && !beat_last;
        cap_d   = ((state_q == ST_RD_WAIT) && resp) || (state_q == ST_RD_DATA);
    end

    line_beat_shifter #(
        .LINE_W (LINE_W),
        .DATA_W (DATA_W)
    ) u_shifter (
        .clk_i       (CLK),
        .reset_i     (RESET),
        .load_i      (load_d),
        .line_i      (wb_line),
        .shift_i     (shift_d),
        .clr_i       (clr_d),
        .cap_i       (cap_d),
        .d_i         (d2_in),
        .last_o      (beat_last),
        .d_out_o     (d2_out),
        .fill_line_o (fill_line)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            is_wr_q    <= 1'b0;
            addr_q     <= '0;
            c2_out_q   <= C2_NOP;
            c2_oe_q    <= 1'b0;
            d2_oe_q    <= 1'b0;
            wb_ack_q   <= 1'b0;
            fill_ack_q <= 1'b0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
            wait_cnt_q <= '0;
        end else begin
            wb_ack_q   <= 1'b0;
            fill_ack_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (wb_req) begin
                        state_q  <= ST_WR_SEND;
                        is_wr_q  <= 1'b1;
                        addr_q   <= wb_addr;
                        c2_out_q <= C2_WRITE_LINE;
                        c2_oe_q  <= 1'b1;
                        d2_oe_q  <= 1'b1;
                        busy_q   <= 1'b1;
                    end else if (fill_req) begin
                        state_q  <= ST_RD_CMD;
                        is_wr_q  <= 1'b0;
                        addr_q   <= fill_addr;
                        c2_out_q <= C2_READ_LINE;
                        c2_oe_q  <= 1'b1;
                        d2_oe_q  <= 1'b0;
                        busy_q   <= 1'b1;
                    end
                end
                ST_WR_SEND: begin
                    if (beat_last) begin
                        state_q    <= ST_WR_WAIT;
                        c2_out_q   <= C2_NOP;
                        c2_oe_q    <= 1'b0;
                        d2_oe_q    <= 1'b0;
                        wait_cnt_q <= '0;
                    end
                end
                ST_RD_CMD: begin
                    state_q    <= ST_RD_WAIT;
                    c2_out_q   <= C2_NOP;
                    c2_oe_q    <= 1'b0;
                    wait_cnt_q <= '0;
                end
                ST_WR_WAIT, ST_RD_WAIT: begin
                    // A single-beat line completes its read on the response edge itself.
                    if ((resp && (state_q == ST_WR_WAIT || beat_last)) || (!resp && wait_expired)) begin
                        state_q    <= ST_DONE;
                        wb_ack_q   <= is_wr_q;
                        fill_ack_q <= !is_wr_q;
                        if (!resp) begin
                            timeout_q <= 1'b1;
                        end
                    end else if (resp) begin
                        state_q <= ST_RD_DATA;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                ST_RD_DATA: begin
                    if (beat_last) begin
                        state_q    <= ST_DONE;
                        fill_ack_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign wb_ack      = wb_ack_q;
    assign fill_ack    = fill_ack_q;
    assign c2_out      = c2_out_q;
    assign c2_oe       = c2_oe_q;
    assign d2_oe       = d2_oe_q;
    assign a2_out      = addr_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

    logic         CLK = 1'b0;
    logic         RESET;
    logic         wb_req;
    logic [11:0]  wb_addr;
    logic [127:0] wb_line;
    logic         wb_ack;
    logic         fill_req;
    logic [11:0]  fill_addr;
    logic         fill_ack;
    logic [127:0] fill_line;
    logic [1:0]   c2_out;
    logic         c2_oe;
    logic [11:0]  a2_out;
    logic [15:0]  d2_out;
    logic         d2_oe;
    logic [1:0]   c2_in;
    logic [15:0]  d2_in;
    logic         busy;
    logic         timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [127:0] line0, line2, line3;

    always #5 CLK = ~CLK;

    mem_bus_arbiter dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .wb_req      (wb_req),
        .wb_addr     (wb_addr),
        .wb_line     (wb_line),
        .wb_ack      (wb_ack),
        .fill_req    (fill_req),
        .fill_addr   (fill_addr),
        .fill_ack    (fill_ack),
        .fill_line   (fill_line),
        .c2_out      (c2_out),
        .c2_oe       (c2_oe),
        .a2_out      (a2_out),
        .d2_out      (d2_out),
        .d2_oe       (d2_oe),
        .c2_in       (c2_in),
        .d2_in       (d2_in),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_wb(input logic [11:0] addr, input logic [127:0] line, input int wait_cyc);
        wb_addr = addr;
        wb_line = line;
        wb_req  = 1'b1;
        tick();
        wb_addr = ~addr;
        wb_line = ~line;
        for (int i = 0; i < 8; i++) begin
            check("wr_cmd", c2_out, 2'd3);
            check("wr_oe", {c2_oe, d2_oe}, 2'b11);
            check("wr_addr", a2_out, addr);
            check("wr_beat", d2_out, line[i*16 +: 16]);
            tick();
        end
        check("wr_release", {c2_oe, d2_oe, c2_out}, 4'b0000);
        check("wr_release_d", d2_out, 16'h0000);
        check("wr_wait_busy", busy, 1'b1);
        for (int k = 0; k < wait_cyc; k++) begin
            check("wr_wait_noack", wb_ack, 1'b0);
            tick();
        end
        c2_in = 2'd1;
        tick();
        c2_in  = 2'd0;
        wb_req = 1'b0;
        check("wb_ack", {wb_ack, fill_ack, busy}, 3'b101);
        tick();
        check("wb_done_idle", {wb_ack, busy}, 2'b00);
    endtask

    task automatic do_fill(input logic [11:0] addr, input logic [127:0] line, input int wait_cyc);
        fill_addr = addr;
        fill_req  = 1'b1;
        tick();
        fill_addr = ~addr;
        check("rd_cmd", c2_out, 2'd2);
        check("rd_oe", {c2_oe, d2_oe}, 2'b10);
        check("rd_addr", a2_out, addr);
        check("rd_busy", busy, 1'b1);
        tick();
        check("rd_release", {c2_oe, d2_oe, c2_out}, 4'b0000);
        for (int k = 0; k < wait_cyc; k++) tick();
        check("rd_wait_noack", fill_ack, 1'b0);
        c2_in = 2'd1;
        d2_in = line[15:0];
        tick();
        c2_in = 2'd0;
        for (int b = 1; b < 8; b++) begin
            d2_in = line[b*16 +: 16];
            tick();
        end
        d2_in = 16'hDEAD;
        check("fill_ack", {fill_ack, wb_ack, busy}, 3'b101);
        check("fill_line", fill_line, line);
        fill_req = 1'b0;
        tick();
        check("fill_done_idle", {fill_ack, busy}, 2'b00);
        check("fill_line_hold", fill_line, line);
    endtask

    initial begin
        RESET     = 1'b1;
        wb_req    = 1'b0;
        wb_addr   = '0;
        wb_line   = '0;
        fill_req  = 1'b0;
        fill_addr = '0;
        c2_in     = 2'd0;
        d2_in     = '0;
        for (int b = 0; b < 16; b++) line0[b*8 +: 8] = 8'(b);
        line2 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        line3 = 128'hA0A1_B2B3_C4C5_D6D7_E8E9_FAFB_0C0D_1E1F;

        tick();
        tick();
        check("rst_ctrl", {c2_oe, d2_oe, wb_ack, fill_ack, busy, timeout_err}, 6'b0);
        check("rst_c2", c2_out, 2'd0);
        check("rst_a2", a2_out, 12'h000);
        check("rst_d2", d2_out, 16'h0000);
        check("rst_fill", fill_line, 128'h0);
        RESET = 1'b0;
        tick();
        check("idle_busy", busy, 1'b0);

        do_wb(12'h2A5, line0, 4);
        do_fill(12'h013, 128'h0007_0006_0005_0004_0003_0002_0001_BEEF, 9);
        check("fill_beat0", fill_line[15:0], 16'hBEEF);

        fill_addr = 12'h055;
        fill_req  = 1'b1;
        do_wb(12'h3F0, line3, 1);
        do_fill(12'h055, line2, 2);

        fill_addr = 12'h0AA;
        fill_req  = 1'b1;
        tick();
        tick();
        for (int k = 0; k < 254; k++) tick();
        check("to_before", {timeout_err, fill_ack, busy}, 3'b001);
        tick();
        check("to_set", {timeout_err, fill_ack, wb_ack}, 3'b110);
        check("to_fill_hold", fill_line, line2);
        fill_req = 1'b0;
        tick();
        check("to_idle", {timeout_err, fill_ack, busy}, 3'b100);
        do_wb(12'h3C3, line3, 2);
        check("to_sticky", timeout_err, 1'b1);

        wb_addr = 12'h123;
        wb_line = line3;
        wb_req  = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        check("mid_beat3", d2_out, line3[63:48]);
        RESET = 1'b1;
        tick();
        check("mid_rst_ctrl", {c2_oe, d2_oe, wb_ack, busy, timeout_err}, 5'b0);
        check("mid_rst_bus", {c2_out, d2_out}, 18'h0);
        check("mid_rst_fill", fill_line, 128'h0);
        RESET  = 1'b0;
        wb_req = 1'b0;
        tick();
        check("mid_no_ack", {wb_ack, busy}, 2'b00);
        do_wb(12'h123, line3, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameters: ADDR_W, default CACHE_TAG_SIZE+CACHE_SET_SIZE, line address width; DATA_W, default DATA2_BUS_SIZE (16), bus2 data width; LINE_BYTES, default CACHE_LINE_SIZE (16); TIMEOUT, default 255, maximum memory wait in cycles.
REQ-002 SHALL use one clock, CLK; reset is RESET, synchronous, active-high.
REQ-003 SHALL have these ports, one per line:
  CLK  in  1  clock
  RESET  in  1  synchronous active-high reset
  wb_req  in  1  writeback request, level, held until wb_ack
  wb_addr  in  ADDR_W  writeback line address
  wb_line  in  LINE_BYTES*8  writeback data, byte 0 in [7:0]
  wb_ack  out  1  one-cycle writeback-complete pulse
  fill_req  in  1  fill request, level, held until fill_ack
  fill_addr  in  ADDR_W  fill line address
  fill_ack  out  1  one-cycle fill-complete pulse
  fill_line  out  LINE_BYTES*8  assembled fill data
  c2_out  out  2  bus2 command driven
  c2_oe  out  1  bus2 command/address drive enable
  a2_out  out  ADDR_W  bus2 address
  d2_out  out  DATA_W  bus2 write data
  d2_oe  out  1  bus2 data drive enable
  c2_in  in  2  bus2 command sampled from memory
  d2_in  in  DATA_W  bus2 read data
  busy  out  1  high in every state except IDLE
  timeout_err  out  1  sticky memory-timeout flag

Function
REQ-004 SHALL implement FSM IDLE, WR_SEND, WR_WAIT, RD_CMD, RD_WAIT, RD_DATA, DONE; all outputs registered.
REQ-005 SHALL arbitrate in IDLE with fixed priority wb_req over fill_req; on simultaneous requests, the writeback is served and fill_req stays pending.
REQ-006 SHALL latch the address (and wb_line) on the grant edge; later changes on request inputs are ignored until ack.
REQ-007 WR_SEND: SHALL run for N=LINE_BYTES*8/DATA_W consecutive cycles with c2_out=C2_WRITE_LINE, c2_oe=d2_oe=1, and a2_out=address; beat i SHALL put line bits [DATA_W*i+DATA_W-1 : DATA_W*i] on d2_out (little-endian).
REQ-008 WR_WAIT: SHALL hold c2_oe=d2_oe=0, then go to DONE on the first edge that samples c2_in==C2_RESPONSE.
REQ-009 RD_CMD: SHALL last one cycle with c2_out=C2_READ_LINE, c2_oe=1, d2_oe=0, then go to RD_WAIT with drives released.
REQ-010 RD_WAIT: on the edge sampling c2_in==C2_RESPONSE, SHALL capture d2_in as beat 0 and enter RD_DATA; RD_DATA SHALL capture beats 1..N-1 on the next N-1 edges without checking c2_in, then enter DONE.
REQ-011 DONE: SHALL last one cycle, pulse the ack of the served requester, and return to IDLE; fill_line SHALL hold its value until the next fill capture.
REQ-012 A wait counter SHALL count cycles in WR_WAIT and RD_WAIT; if TIMEOUT cycles pass without C2_RESPONSE, the block SHALL set timeout_err, go to DONE, and still pulse the ack.
REQ-013 Back-to-back operation: a request pending in DONE SHALL be granted on the first IDLE edge, giving at least 1 idle cycle between transactions.
REQ-014 When not driving, c2_out SHALL be C2_NOP and d2_out SHALL be 0.
REQ-015 Beat counter SHALL be $clog2(N) bits wide, count 0..N-1, and not wrap within a transaction.

Reset
REQ-016 RESET SHALL, in any state including mid-transfer, force IDLE; c2_oe, d2_oe, wb_ack, fill_ack, busy and timeout_err to 0; c2_out to C2_NOP; a2_out, d2_out and fill_line to 0; and clear the counters and latched request.
REQ-017 An interrupted transaction SHALL NOT be acked; the requester re-requests.

Structure
REQ-018 The shared bus package SHALL hold the C2 encodings (C2_NOP=0, C2_RESPONSE=1, C2_READ_LINE=2, C2_WRITE_LINE=3), the FSM state typedef, and CACHE_LINE_SIZE/DATA2_BUS_SIZE.
REQ-019 The line serializer/deserializer (beat counter, mux and capture) SHALL be the single sub-module line_beat_shifter.

Verification
REQ-020 Writeback with wb_addr=0x2A5 and wb_line bytes 0x00..0x0F -> 8 WR_SEND cycles with d2_out 0x0100, 0x0302, ..., 0x0F0E; response 5 cycles later -> wb_ack 1 cycle after.
REQ-021 Fill from 0x013 with memory response after 10 cycles and beats 0xBEEF, 0x0001..0x0007 -> fill_line[15:0]=0xBEEF, fill_ack pulse, busy low next cycle.
REQ-022 wb_req and fill_req raised on the same edge -> write completes first, then RD_CMD on the first IDLE edge after wb_ack.
REQ-023 No response in RD_WAIT -> after 255 cycles timeout_err=1, fill_ack pulse, and timeout_err stays set through later transactions until RESET.
REQ-024 RESET at beat 3 of WR_SEND -> next cycle IDLE, c2_oe=0, no wb_ack; a re-request restarts at beat 0.
